npu_config_sequencer: RTL and testbench

Drains 26-bit configuration words from the NPU config FIFO, decodes them and writes weights/control words into the nine large circular buffers and the one small circular buffer. It also sequences NPU config resets and gates datapath start. It sits between the config FIFO and the cbuf array inside the npu top level; PEs and the cbuf read side must not run until cfg_done is high.

---
 rtl/npu_cfg_pkg.sv | 53 +++++
 rtl/npu_cfg_decode.sv | 54 +++++
 rtl/npu_config_sequencer.sv | 154 +++++++++++++++
 tb/tb_npu_config_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_cfg_pkg.sv
// Shared constants, field positions, command/error encodings and FSM states
// for the NPU configuration sequencer.
package npu_cfg_pkg;

    localparam int unsigned NUM_LARGE   = 9;
    localparam int unsigned LARGE_DEPTH = 8;
    localparam int unsigned SMALL_DEPTH = 16;
    localparam int unsigned DATA_W      = 16;
    localparam int unsigned CFG_W       = 26;
    localparam int unsigned CLR_CYCLES  = 2;

    localparam int unsigned NUM_BUF = NUM_LARGE + 1;
    localparam int unsigned DEST_W  = 4;
    localparam int unsigned CNT_W   = $clog2(SMALL_DEPTH + 1);
    localparam int unsigned CLR_W   = $clog2(CLR_CYCLES + 1);

    localparam int unsigned CMD_MSB  = 25;
    localparam int unsigned CMD_LSB  = 24;
    localparam int unsigned DEST_MSB = 23;
    localparam int unsigned DEST_LSB = 20;
    localparam int unsigned RSVD_MSB = 19;
    localparam int unsigned RSVD_LSB = 16;
    localparam int unsigned DATA_MSB = 15;
    localparam int unsigned DATA_LSB = 0;

    typedef enum logic [1:0] {
        CMD_WRITE  = 2'b00,
        CMD_COMMIT = 2'b01,
        CMD_CLEAR  = 2'b10,
        CMD_NOP    = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        ERR_NONE         = 2'd0,
        ERR_BAD_DEST     = 2'd1,
        ERR_OVERFLOW     = 2'd2,
        ERR_AFTER_COMMIT = 2'd3
    } err_code_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP,
        ST_DECODE,
        ST_WAIT_IDLE,
        ST_CLEAR,
        ST_ERR
    } state_e;

    function automatic logic [CNT_W-1:0] buf_depth(input logic [DEST_W-1:0] dest);
        return (dest == DEST_W'(NUM_LARGE)) ? CNT_W'(SMALL_DEPTH) : CNT_W'(LARGE_DEPTH);
    endfunction

endpackage

// File: rtl/npu_cfg_decode.sv
// Combinational config-word decode and WRITE legality check against the
// per-buffer fill counters and the commit flag.
module npu_cfg_decode
    import npu_cfg_pkg::*;
(
    input  logic [CFG_W-1:0]              cfg_word,
    input  logic [NUM_BUF-1:0][CNT_W-1:0] cnt_vec,
    input  logic                          cfg_done,
    output cmd_e                          cmd,
    output logic [DEST_W-1:0]             dest,
    output logic [DATA_W-1:0]             data,
    output logic                          wr_ok,
    output logic                          err,
    output err_code_e                     err_code
);

    logic [CNT_W-1:0] sel_cnt;
    logic             unused_rsvd;

    assign unused_rsvd = ^cfg_word[RSVD_MSB:RSVD_LSB];

    always_comb begin
        cmd      = cmd_e'(cfg_word[CMD_MSB:CMD_LSB]);
        dest     = cfg_word[DEST_MSB:DEST_LSB];
        data     = cfg_word[DATA_MSB:DATA_LSB];
        sel_cnt  = '0;
        wr_ok    = 1'b0;
        err      = 1'b0;
        err_code = ERR_NONE;

        for (int unsigned i = 0; i < NUM_BUF; i++) begin
            if (dest == DEST_W'(i)) begin
                sel_cnt = cnt_vec[i];
            end
        end

        // Checks are priority ordered: bad destination beats overflow beats late write.
        if (cmd == CMD_WRITE) begin
            if (dest > DEST_W'(NUM_LARGE)) begin
                err      = 1'b1;
                err_code = ERR_BAD_DEST;
            end else if (sel_cnt == buf_depth(dest)) begin
                err      = 1'b1;
                err_code = ERR_OVERFLOW;
            end else if (cfg_done) begin
                err      = 1'b1;
                err_code = ERR_AFTER_COMMIT;
            end else begin
                wr_ok = 1'b1;
            end
        end
    end

endmodule

// File: rtl/npu_config_sequencer.sv
// Drains config words from the config FIFO, writes cbufs, tracks commit state
// and sequences the NPU config reset pulse.
module npu_config_sequencer
    import npu_cfg_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    input  logic               cfg_empty,
    input  logic [CFG_W-1:0]   cfg_dout,
    output logic               cfg_rd_en,
    input  logic               npu_idle,
    output logic [NUM_BUF-1:0] cbuf_wr_en,
    output logic [DATA_W-1:0]  cbuf_wr_data,
    output logic               npu_cfg_rst,
    output logic               cfg_done,
    output logic               cfg_err,
    output logic [1:0]         cfg_err_code
);

    state_e                        state_q, state_d;
    cmd_e                          cmd_q, cmd_d;
    logic [NUM_BUF-1:0]            wr_en_q, wr_en_d;
    logic [DATA_W-1:0]             wr_data_q, wr_data_d;
    logic [NUM_BUF-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic                          done_q, done_d;
    logic                          err_q, err_d;
    logic [1:0]                    err_code_q, err_code_d;
    logic [CLR_W-1:0]              clr_cnt_q, clr_cnt_d;
    logic                          out_en_q, out_en_d;

    cmd_e              dec_cmd;
    logic [DEST_W-1:0] dec_dest;
    logic [DATA_W-1:0] dec_data;
    logic              dec_wr_ok;
    logic              dec_err;
    err_code_e         dec_err_code;

    npu_cfg_decode u_decode (
        .cfg_word (cfg_dout),
        .cnt_vec  (cnt_q),
        .cfg_done (done_q),
        .cmd      (dec_cmd),
        .dest     (dec_dest),
        .data     (dec_data),
        .wr_ok    (dec_wr_ok),
        .err      (dec_err),
        .err_code (dec_err_code)
    );

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        wr_en_d     = '0;
        wr_data_d   = wr_data_q;
        cnt_d       = cnt_q;
        done_d      = done_q;
        err_d       = err_q;
        err_code_d  = err_code_q;
        clr_cnt_d   = clr_cnt_q;
        out_en_d    = 1'b1;
        cfg_rd_en   = 1'b0;
        npu_cfg_rst = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // out_en_q keeps the pop off while reset is held with a non-empty FIFO.
                if (out_en_q && !cfg_empty) begin
                    cfg_rd_en = 1'b1;
                    state_d   = ST_POP;
                end
            end
            ST_POP: begin
                // The word is decoded as it is captured so the strobe lands two cycles after the pop.
                state_d = ST_DECODE;
                cmd_d   = dec_cmd;
                if (dec_err) begin
                    err_d      = 1'b1;
                    err_code_d = dec_err_code;
                    done_d     = 1'b0;
                end else if (dec_wr_ok) begin
                    wr_en_d         = NUM_BUF'(1) << dec_dest;
                    wr_data_d       = dec_data;
                    cnt_d[dec_dest] = cnt_q[dec_dest] + CNT_W'(1);
                end else if (dec_cmd == CMD_COMMIT) begin
                    done_d = 1'b1;
                end
            end
            ST_DECODE: begin
                if (err_q) begin
                    state_d = ST_ERR;
                end else if (cmd_q == CMD_CLEAR) begin
                    state_d = ST_WAIT_IDLE;
                    done_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (npu_idle) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            ST_CLEAR: begin
                npu_cfg_rst = 1'b1;
                cnt_d       = '0;
                if (clr_cnt_q == CLR_W'(CLR_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + CLR_W'(1);
                end
            end
            ST_ERR: begin
                done_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            cmd_q      <= CMD_NOP;
            wr_en_q    <= '0;
            wr_data_q  <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= '0;
            clr_cnt_q  <= '0;
            out_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            clr_cnt_q  <= clr_cnt_d;
            out_en_q   <= out_en_d;
        end
    end

    assign cbuf_wr_en   = wr_en_q;
    assign cbuf_wr_data = wr_data_q;
    assign cfg_done     = done_q;
    assign cfg_err      = err_q;
    assign cfg_err_code = err_code_q;

endmodule

// File: tb/tb_npu_config_sequencer.sv
// Directed bench for npu_config_sequencer with a simple config FIFO model.
`timescale 1ns/1ps
module tb_npu_config_sequencer;
    import npu_cfg_pkg::*;

    logic        CLK;
    logic        RST;
    logic        cfg_empty;
    logic [25:0] cfg_dout;
    logic        cfg_rd_en;
    logic        npu_idle;
    logic [9:0]  cbuf_wr_en;
    logic [15:0] cbuf_wr_data;
    logic        npu_cfg_rst;
    logic        cfg_done;
    logic        cfg_err;
    logic [1:0]  cfg_err_code;

    int tests = 0;
    int fails = 0;

    logic [25:0] fifo_mem [256];
    int          wr_ptr = 0;
    int          rd_ptr = 0;

    int          strobes [10] = '{default: 0};
    logic [15:0] last_data [10];
    int          viol = 0;
    int          cyc = 0;
    int          last_pop = -100;

    npu_config_sequencer dut (
        .CLK          (CLK),
        .RST          (RST),
        .cfg_empty    (cfg_empty),
        .cfg_dout     (cfg_dout),
        .cfg_rd_en    (cfg_rd_en),
        .npu_idle     (npu_idle),
        .cbuf_wr_en   (cbuf_wr_en),
        .cbuf_wr_data (cbuf_wr_data),
        .npu_cfg_rst  (npu_cfg_rst),
        .cfg_done     (cfg_done),
        .cfg_err      (cfg_err),
        .cfg_err_code (cfg_err_code)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign cfg_empty = (wr_ptr == rd_ptr);

    always @(posedge CLK) begin
        if (cfg_rd_en && (wr_ptr != rd_ptr)) begin
            cfg_dout <= fifo_mem[rd_ptr[7:0]];
            rd_ptr   <= rd_ptr + 1;
        end
    end

    // Invariant monitor: pop while empty, pops closer than 2 cycles, non-one-hot
    // strobes, strobes during config reset or after commit.
    always @(negedge CLK) begin
        cyc = cyc + 1;
        if (cfg_rd_en) begin
            if (cfg_empty) viol = viol + 1;
            if (cyc - last_pop < 2) viol = viol + 1;
            last_pop = cyc;
        end
        if (cbuf_wr_en != 10'b0) begin
            if (!$onehot(cbuf_wr_en) || npu_cfg_rst || cfg_done) viol = viol + 1;
            for (int i = 0; i < 10; i++) begin
                if (cbuf_wr_en[i]) begin
                    strobes[i]   = strobes[i] + 1;
                    last_data[i] = cbuf_wr_data;
                end
            end
        end
    end

    function automatic logic [25:0] mk(input logic [1:0] cmd, input logic [3:0] dest, input logic [15:0] data);
        return {cmd, dest, 4'h0, data};
    endfunction

    task automatic push(input logic [25:0] w);
        fifo_mem[wr_ptr[7:0]] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST      = 1'b0;
        npu_idle = 1'b0;
        wr_ptr   = rd_ptr;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
    endtask

    task automatic drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (wr_ptr == rd_ptr) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (4) @(negedge CLK);
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RST      = 1'b0;
        npu_idle = 1'b0;
        push(mk(CMD_WRITE, 4'd0, 16'hBEEF));
        repeat (2) @(negedge CLK);
        tests++; if (cfg_rd_en !== 1'b0) begin fails++; $display("FAIL reset_rd_en: got %b expected 0", cfg_rd_en); end
        tests++; if (cbuf_wr_en !== 10'b0) begin fails++; $display("FAIL reset_wr_en: got %b expected 0", cbuf_wr_en); end
        tests++; if (cbuf_wr_data !== 16'h0) begin fails++; $display("FAIL reset_wr_data: got %h expected 0", cbuf_wr_data); end
        tests++; if (npu_cfg_rst !== 1'b0) begin fails++; $display("FAIL reset_cfg_rst: got %b expected 0", npu_cfg_rst); end
        tests++; if (cfg_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", cfg_done); end
        tests++; if ({cfg_err, cfg_err_code} !== 3'b000) begin fails++; $display("FAIL reset_err: got %b expected 000", {cfg_err, cfg_err_code}); end
        wr_ptr = rd_ptr;
        RST = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_single_write();
        bit found;
        do_reset();
        push(mk(CMD_WRITE, 4'd3, 16'h1234));
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            #1;
            if (cfg_rd_en) found = 1'b1;
            else @(negedge CLK);
        end
        tests++; if (found !== 1'b1) begin fails++; $display("FAIL single_pop: got %b expected 1", found); end
        @(negedge CLK);
        tests++; if (cbuf_wr_en !== 10'b0) begin fails++; $display("FAIL single_t1_wr_en: got %b expected 0", cbuf_wr_en); end
        @(negedge CLK);
        tests++; if (cbuf_wr_en !== 10'b0000001000) begin fails++; $display("FAIL single_t2_wr_en: got %b expected 0000001000", cbuf_wr_en); end
        tests++; if (cbuf_wr_data !== 16'h1234) begin fails++; $display("FAIL single_t2_data: got %h expected 1234", cbuf_wr_data); end
        @(negedge CLK);
        tests++; if (cbuf_wr_en !== 10'b0) begin fails++; $display("FAIL single_t3_wr_en: got %b expected 0", cbuf_wr_en); end
    endtask

    task automatic test_fill_large();
        bit ok;
        int s;
        do_reset();
        s = strobes[0];
        for (int i = 0; i < 8; i++) push(mk(CMD_WRITE, 4'd0, 16'h0100 + 16'(i)));
        push(mk(CMD_COMMIT, 4'd0, 16'h0));
        drain(ok);
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL fill_drain: got %b expected 1", ok); end
        tests++; if (strobes[0] - s !== 8) begin fails++; $display("FAIL fill_strobes: got %0d expected 8", strobes[0] - s); end
        tests++; if (last_data[0] !== 16'h0107) begin fails++; $display("FAIL fill_last_data: got %h expected 0107", last_data[0]); end
        tests++; if (cfg_done !== 1'b1) begin fails++; $display("FAIL fill_done: got %b expected 1", cfg_done); end
        tests++; if (cfg_err !== 1'b0) begin fails++; $display("FAIL fill_err: got %b expected 0", cfg_err); end
    endtask

    task automatic test_overflow();
        bit ok;
        int s;
        do_reset();
        s = strobes[0];
        for (int i = 0; i < 9; i++) push(mk(CMD_WRITE, 4'd0, 16'h0200 + 16'(i)));
        push(mk(CMD_COMMIT, 4'd0, 16'h0));
        drain(ok);
        tests++; if (ok !== 1'b0) begin fails++; $display("FAIL ovf_commit_left: got drained=%b expected 0", ok); end
        tests++; if (strobes[0] - s !== 8) begin fails++; $display("FAIL ovf_strobes: got %0d expected 8", strobes[0] - s); end
        tests++; if (last_data[0] !== 16'h0207) begin fails++; $display("FAIL ovf_last_data: got %h expected 0207", last_data[0]); end
        tests++; if (cfg_err !== 1'b1) begin fails++; $display("FAIL ovf_err: got %b expected 1", cfg_err); end
        tests++; if (cfg_err_code !== 2'd2) begin fails++; $display("FAIL ovf_code: got %0d expected 2", cfg_err_code); end
        tests++; if (cfg_done !== 1'b0) begin fails++; $display("FAIL ovf_done: got %b expected 0", cfg_done); end
    endtask

    task automatic test_small_and_bad_dest();
        bit ok;
        int s;
        int rd_high;
        do_reset();
        s = strobes[9];
        for (int i = 0; i < 16; i++) push(mk(CMD_WRITE, 4'd9, 16'h0900 + 16'(i)));
        drain(ok);
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL small_drain: got %b expected 1", ok); end
        tests++; if (strobes[9] - s !== 16) begin fails++; $display("FAIL small_strobes: got %0d expected 16", strobes[9] - s); end
        tests++; if (last_data[9] !== 16'h090F) begin fails++; $display("FAIL small_last_data: got %h expected 090f", last_data[9]); end
        tests++; if (cfg_err !== 1'b0) begin fails++; $display("FAIL small_err: got %b expected 0", cfg_err); end
        push(mk(CMD_WRITE, 4'd10, 16'hDEAD));
        push(mk(CMD_NOP, 4'd0, 16'h0));
        repeat (6) @(negedge CLK);
        tests++; if (cfg_err !== 1'b1) begin fails++; $display("FAIL baddest_err: got %b expected 1", cfg_err); end
        tests++; if (cfg_err_code !== 2'd1) begin fails++; $display("FAIL baddest_code: got %0d expected 1", cfg_err_code); end
        rd_high = 0;
        repeat (10) begin
            @(negedge CLK);
            if (cfg_rd_en) rd_high++;
        end
        tests++; if (rd_high !== 0) begin fails++; $display("FAIL baddest_rd_en: got %0d pops expected 0", rd_high); end
        tests++; if (wr_ptr - rd_ptr !== 1) begin fails++; $display("FAIL baddest_fifo_level: got %0d expected 1", wr_ptr - rd_ptr); end
    endtask

    task automatic test_write_after_commit();
        bit ok;
        int s;
        do_reset();
        s = strobes[1];
        push(mk(CMD_WRITE, 4'd1, 16'h1111));
        push(mk(CMD_COMMIT, 4'd0, 16'h0));
        push(mk(CMD_WRITE, 4'd1, 16'h2222));
        drain(ok);
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL late_drain: got %b expected 1", ok); end
        tests++; if (strobes[1] - s !== 1) begin fails++; $display("FAIL late_strobes: got %0d expected 1", strobes[1] - s); end
        tests++; if (last_data[1] !== 16'h1111) begin fails++; $display("FAIL late_last_data: got %h expected 1111", last_data[1]); end
        tests++; if (cfg_err !== 1'b1) begin fails++; $display("FAIL late_err: got %b expected 1", cfg_err); end
        tests++; if (cfg_err_code !== 2'd3) begin fails++; $display("FAIL late_code: got %0d expected 3", cfg_err_code); end
        tests++; if (cfg_done !== 1'b0) begin fails++; $display("FAIL late_done: got %b expected 0", cfg_done); end
    endtask

    task automatic test_clear();
        bit ok;
        int s;
        int rst_high;
        do_reset();
        s = strobes[0];
        for (int i = 0; i < 8; i++) push(mk(CMD_WRITE, 4'd0, 16'h0300 + 16'(i)));
        push(mk(CMD_COMMIT, 4'd0, 16'h0));
        drain(ok);
        tests++; if (cfg_done !== 1'b1) begin fails++; $display("FAIL clear_pre_done: got %b expected 1", cfg_done); end
        push(mk(CMD_CLEAR, 4'd0, 16'h0));
        drain(ok);
        tests++; if (cfg_done !== 1'b0) begin fails++; $display("FAIL clear_done_drop: got %b expected 0", cfg_done); end
        rst_high = 0;
        repeat (5) begin
            @(negedge CLK);
            if (npu_cfg_rst) rst_high++;
        end
        tests++; if (rst_high !== 0) begin fails++; $display("FAIL clear_wait_idle: got %0d rst cycles expected 0", rst_high); end
        npu_idle = 1'b1;
        rst_high = 0;
        repeat (6) begin
            @(negedge CLK);
            if (npu_cfg_rst) rst_high++;
        end
        tests++; if (rst_high !== 2) begin fails++; $display("FAIL clear_rst_width: got %0d expected 2", rst_high); end
        for (int i = 0; i < 8; i++) push(mk(CMD_WRITE, 4'd0, 16'h0400 + 16'(i)));
        drain(ok);
        tests++; if (strobes[0] - s !== 16) begin fails++; $display("FAIL clear_refill_strobes: got %0d expected 16", strobes[0] - s); end
        tests++; if (last_data[0] !== 16'h0407) begin fails++; $display("FAIL clear_refill_data: got %h expected 0407", last_data[0]); end
        tests++; if (cfg_err !== 1'b0) begin fails++; $display("FAIL clear_refill_err: got %b expected 0", cfg_err); end
        tests++; if (cfg_done !== 1'b0) begin fails++; $display("FAIL clear_refill_done: got %b expected 0", cfg_done); end
    endtask

    task automatic test_reset_mid_clear();
        bit found;
        do_reset();
        npu_idle = 1'b1;
        push(mk(CMD_CLEAR, 4'd0, 16'h0));
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge CLK);
            if (npu_cfg_rst) found = 1'b1;
        end
        tests++; if (found !== 1'b1) begin fails++; $display("FAIL midclr_rst_seen: got %b expected 1", found); end
        #2;
        RST = 1'b0;
        #1;
        tests++; if (npu_cfg_rst !== 1'b0) begin fails++; $display("FAIL midclr_rst_async: got %b expected 0", npu_cfg_rst); end
        tests++; if ({cfg_rd_en, cfg_done, cfg_err} !== 3'b000) begin fails++; $display("FAIL midclr_outs: got %b expected 000", {cfg_rd_en, cfg_done, cfg_err}); end
        tests++; if (cbuf_wr_en !== 10'b0) begin fails++; $display("FAIL midclr_wr_en: got %b expected 0", cbuf_wr_en); end
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_back_to_back();
        bit ok;
        int s2;
        int s4;
        do_reset();
        s2 = strobes[2];
        s4 = strobes[4];
        push(mk(CMD_WRITE, 4'd2, 16'hAAAA));
        drain(ok);
        repeat (3) @(negedge CLK);
        push(mk(CMD_WRITE, 4'd2, 16'h5555));
        push(mk(CMD_NOP, 4'd2, 16'hFFFF));
        push({CMD_WRITE, 4'd4, 4'hF, 16'h0F0F});
        drain(ok);
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL b2b_drain: got %b expected 1", ok); end
        tests++; if (strobes[2] - s2 !== 2) begin fails++; $display("FAIL b2b_strobes2: got %0d expected 2", strobes[2] - s2); end
        tests++; if (last_data[2] !== 16'h5555) begin fails++; $display("FAIL b2b_data2: got %h expected 5555", last_data[2]); end
        tests++; if (strobes[4] - s4 !== 1) begin fails++; $display("FAIL b2b_strobes4: got %0d expected 1", strobes[4] - s4); end
        tests++; if (last_data[4] !== 16'h0F0F) begin fails++; $display("FAIL b2b_data4: got %h expected 0f0f", last_data[4]); end
        tests++; if (cfg_err !== 1'b0) begin fails++; $display("FAIL b2b_err: got %b expected 0", cfg_err); end
    endtask

    task automatic test_invariants();
        tests++; if (viol !== 0) begin fails++; $display("FAIL invariants: got %0d violations expected 0", viol); end
    endtask

    initial begin
        RST      = 1'b0;
        npu_idle = 1'b0;
        test_reset();
        test_single_write();
        test_fill_large();
        test_overflow();
        test_small_and_bad_dest();
        test_write_after_commit();
        test_clear();
        test_reset_mid_clear();
        test_back_to_back();
        test_invariants();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
